// File: rtl/alu_mdu_controller.sv
// alu_mdu_controller: registered base ALU decode plus iterative RV32M multiply/divide unit
// Ports:
//   clk, rst_n          core clock, synchronous active-low reset
//   in_valid/in_ready   decode handshake; in_ready high only while IDLE
//   ALUOp/Funct7/Funct3 instruction decode fields
//   src_a, src_b        MDU operands, sampled on accept
//   out_valid           one-cycle pulse qualifying Operation/md_*
//   Operation           base ALU operation (0 for M ops)
//   md_sel/md_result    MDU result select and value
//   md_illegal          M op not supported in this build
//   stall               inverse of in_ready
// Build option: define MDU_DIV_EN to include DIV/DIVU/REM/REMU; otherwise they report md_illegal.
module alu_mdu_controller #(
    parameter int XLEN = 32,
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    output logic [OP_W-1:0] Operation,
    output logic            md_sel,
    output logic [XLEN-1:0] md_result,
    output logic            md_illegal,
    output logic            stall
);
    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, FIX = 2'd2;

    logic [1:0]        state;
    logic [CW-1:0]     count;
    logic [XLEN:0]     acc;
    logic [XLEN-1:0]   lo, dvs;
    logic [2:0]        fn;
    logic              neg_q, neg_r;
    logic              accept, is_m, sign_a, sign_b;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [3:0]        base_op;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod, prod_c;
    logic [XLEN-1:0]   q_c, r_c, res;

    assign in_ready = state == IDLE;
    assign stall    = !in_ready;
    assign accept   = in_valid && in_ready;
    assign is_m     = ALUOp == 2'b10 && Funct7 == 7'b0000001;
    // rs1 is signed for MULH/MULHSU/DIV/REM, rs2 only for MULH/DIV/REM
    assign sign_a   = (Funct3[2] ? !Funct3[0] : Funct3[1] ^ Funct3[0]) && src_a[XLEN-1];
    assign sign_b   = (Funct3[2] ? !Funct3[0] : Funct3[1:0] == 2'b01) && src_b[XLEN-1];
    assign abs_a    = sign_a ? -src_a : src_a;
    assign abs_b    = sign_b ? -src_b : src_b;
    // {acc, lo} is the running product (multiply) or remainder:quotient pair (divide)
    assign mul_sum  = {1'b0, acc[XLEN-1:0]} + (lo[0] ? {1'b0, dvs} : '0);
    assign prod     = {acc[XLEN-1:0], lo};
    assign prod_c   = neg_q ? -prod : prod;
    assign q_c      = neg_q ? -lo : lo;
    assign r_c      = neg_r ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign res      = fn[2] ? (fn[1] ? r_c : q_c) :
                      fn[1:0] == 2'b00 ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];

`ifdef MDU_DIV_EN
    logic [XLEN:0] div_sh, div_diff;
    logic          div0, ovf;
    assign div_sh   = {acc[XLEN-1:0], lo[XLEN-1]};
    assign div_diff = div_sh - {1'b0, dvs};
    assign div0     = src_b == '0;
    assign ovf      = !Funct3[0] && src_a == {1'b1, {(XLEN-1){1'b0}}} && src_b == '1;
`endif

    always_comb begin
        base_op = 4'b0010;
        if (ALUOp == 2'b01)
            case (Funct3)
                3'b000:  base_op = 4'b1000;
                3'b001:  base_op = 4'b1110;
                3'b100:  base_op = 4'b1010;
                3'b101:  base_op = 4'b1011;
                default: base_op = 4'b0000;
            endcase
        else if (ALUOp == 2'b10)
            case (Funct3)
                3'b000:  base_op = Funct7[5] ? 4'b0110 : 4'b0010;
                3'b001:  base_op = 4'b1001;
                3'b010:  base_op = 4'b0111;
                3'b100:  base_op = 4'b0101;
                3'b101:  base_op = Funct7[5] ? 4'b0100 : 4'b1101;
                3'b110:  base_op = 4'b0001;
                default: base_op = 4'b0000;
            endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            acc        <= '0;
            lo         <= '0;
            dvs        <= '0;
            fn         <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            out_valid  <= 1'b0;
            Operation  <= '0;
            md_sel     <= 1'b0;
            md_result  <= '0;
            md_illegal <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (!is_m) begin
                        out_valid  <= 1'b1;
                        Operation  <= OP_W'(base_op);
                        md_sel     <= 1'b0;
                        md_illegal <= 1'b0;
                    end
`ifndef MDU_DIV_EN
                    else if (Funct3[2]) begin
                        out_valid  <= 1'b1;
                        Operation  <= '0;
                        md_sel     <= 1'b1;
                        md_result  <= '0;
                        md_illegal <= 1'b1;
                    end
`endif
                    else begin
                        fn    <= Funct3;
                        acc   <= '0;
                        lo    <= abs_a;
                        dvs   <= abs_b;
                        neg_q <= sign_a ^ sign_b;
                        neg_r <= sign_a;
                        count <= CW'(XLEN - 1);
                        state <= BUSY;
`ifdef MDU_DIV_EN
                        // preload the final quotient/remainder so FIX selects them unchanged
                        if (Funct3[2] && (div0 || ovf)) begin
                            lo    <= div0 ? '1 : src_a;
                            acc   <= div0 ? {1'b0, src_a} : '0;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= FIX;
                        end
`endif
                    end
                end
                BUSY: begin
`ifdef MDU_DIV_EN
                    if (fn[2]) begin
                        acc <= div_diff[XLEN] ? div_sh : div_diff;
                        lo  <= {lo[XLEN-2:0], ~div_diff[XLEN]};
                    end else
`endif
                    {acc, lo} <= {1'b0, mul_sum, lo[XLEN-1:1]};
                    if (count == '0) state <= FIX;
                    else count <= count - 1'b1;
                end
                FIX: begin
                    out_valid  <= 1'b1;
                    Operation  <= '0;
                    md_sel     <= 1'b1;
                    md_result  <= res;
                    md_illegal <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mdu_controller.sv
// tb_alu_mdu_controller: scoreboard bench for alu_mdu_controller against a behavioural model
module tb_alu_mdu_controller;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
    logic [1:0]  ALUOp = '0;
    logic [6:0]  Funct7 = '0;
    logic [2:0]  Funct3 = '0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        in_ready, out_valid, md_sel, md_illegal, stall;
    logic [3:0]  Operation;
    logic [31:0] md_result;

    alu_mdu_controller #(.XLEN(32), .OP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .Operation(Operation), .md_sel(md_sel),
        .md_result(md_result), .md_illegal(md_illegal), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [3:0]  op;
        logic        sel;
        logic [31:0] res;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0, ready_at = 0, n_cmp = 0, n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [3:0] base_model(logic [1:0] op, logic [6:0] f7, logic [2:0] f3);
        logic [3:0] br [8] = '{4'b1000, 4'b1110, 4'b0000, 4'b0000, 4'b1010, 4'b1011, 4'b0000, 4'b0000};
        logic [3:0] rt [8] = '{4'b0010, 4'b1001, 4'b0111, 4'b0000, 4'b0101, 4'b1101, 4'b0001, 4'b0000};
        if (op == 2'b01) return br[f3];
        if (op != 2'b10) return 4'b0010;
        if (f7 == 7'b0100000 && f3 == 3'b000) return 4'b0110;
        if (f7 == 7'b0100000 && f3 == 3'b101) return 4'b0100;
        return rt[f3];
    endfunction

    function automatic exp_t model(logic [1:0] op, logic [6:0] f7, logic [2:0] f3,
                                   logic [31:0] a, logic [31:0] b);
        exp_t r;
        logic [63:0] pp;
        logic ovf;
        r = '{due: 1, op: base_model(op, f7, f3), sel: 1'b0, res: 32'h0, ill: 1'b0};
        if (!(op == 2'b10 && f7 == 7'b0000001)) return r;
        r.op  = 4'b0000;
        r.sel = 1'b1;
        ovf   = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        pp    = '0;
        case (f3)
            3'd0: r.res = a * b;
            3'd1: pp = longint'($signed(a)) * longint'($signed(b));
            3'd2: pp = longint'($signed(a)) * longint'({32'b0, b});
            3'd3: pp = {32'b0, a} * {32'b0, b};
            3'd4: r.res = b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: r.res = b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6: r.res = b == 0 ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: r.res = b == 0 ? a : a % b;
        endcase
        if (f3 inside {3'd1, 3'd2, 3'd3}) r.res = pp[63:32];
        r.due = (f3[2] && (b == 0 || (ovf && !f3[0]))) ? 2 : 34;
`ifndef MDU_DIV_EN
        if (f3[2]) begin
            r.due = 1;
            r.res = 32'h0;
            r.ill = 1'b1;
        end
`endif
        return r;
    endfunction

    task automatic issue(logic [1:0] op, logic [6:0] f7, logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        exp_t x;
        int waited = 0;
        @(negedge clk);
        ALUOp = op; Funct7 = f7; Funct3 = f3; src_a = a; src_b = b; in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1'b1);
            in_valid = 1'b0;
            return;
        end
        x = model(op, f7, f3, a, b);
        x.due += cyc;
        ready_at = x.due;
        sb.push_back(x);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        check("in_ready", in_ready, cyc >= ready_at);
        check("stall", stall, cyc < ready_at);
        if (sb.size() == 0) check("spurious_out_valid", out_valid, 1'b0);
        else if (out_valid) begin
            e = sb.pop_front();
            check("out_valid_cycle", cyc, e.due);
            check("Operation", Operation, e.op);
            check("md_sel", md_sel, e.sel);
            check("md_illegal", md_illegal, e.ill);
            if (e.sel) check("md_result", md_result, e.res);
        end
        while (sb.size() > 0 && sb[0].due < cyc) begin
            check("missing_out_valid", sb[0].due, cyc);
            void'(sb.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] op;
        logic [6:0] f7;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_Operation", Operation, 4'h0);
        check("rst_md_sel", md_sel, 1'b0);
        check("rst_md_result", md_result, 32'h0);
        check("rst_md_illegal", md_illegal, 1'b0);
        rst_n = 1'b1;
        issue(2'b01, 7'h00, 3'b001, 32'h0, 32'h0);
        issue(2'b10, 7'h00, 3'b000, 32'h0, 32'h0);
        issue(2'b10, 7'h20, 3'b000, 32'h0, 32'h0);
        issue(2'b10, 7'h01, 3'b000, 32'd7, 32'hFFFF_FFFD);
        issue(2'b10, 7'h01, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'b10, 7'h01, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'b10, 7'h01, 3'b010, 32'hFFFF_FFFF, 32'h0000_0003);
        issue(2'b10, 7'h01, 3'b100, 32'hFFFF_FFF9, 32'd2);
        issue(2'b10, 7'h01, 3'b110, 32'hFFFF_FFF9, 32'd2);
        issue(2'b10, 7'h01, 3'b101, 32'd100, 32'd7);
        issue(2'b10, 7'h01, 3'b100, 32'd5, 32'd0);
        issue(2'b10, 7'h01, 3'b110, 32'd5, 32'd0);
        issue(2'b10, 7'h01, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'b10, 7'h01, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'b10, 7'h01, 3'b111, 32'd100, 32'd7);
        idle(40);
        issue(2'b10, 7'h01, 3'b000, 32'd12345, 32'd678);
        idle(10);
        rst_n = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        ready_at = 0;
        @(negedge clk);
        rst_n = 1'b1;
        check("ready_after_reset", in_ready, 1'b1);
        issue(2'b10, 7'h00, 3'b000, 32'h0, 32'h0);
        idle(2);
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                op = 2'($urandom_range(0, 3));
                f7 = op == 2'b10 ? ($urandom_range(0, 1) ? 7'b0100000 : 7'b0000000) : 7'($urandom);
                issue(op, f7, 3'($urandom_range(0, 7)), pick(), pick());
            end else
                issue(2'b10, 7'b0000001, 3'($urandom_range(0, 7)), pick(), pick());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
        check("drain", sb.size(), 0);
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
